cpu_sequencer: RTL and testbench

Multi-cycle fetch/decode/execute controller for the single-issue CPU datapath (instruction RAM, data RAM, register bank, memory control, ALU). Replaces hand-driven testbench sequencing: owns the program counter, fetches from instruction RAM, latches the instruction word, evaluates the condition field against a held flag register, and sequences data-RAM access and register write-back. One instruction in flight; no pipelining.

---
 rtl/cpu_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute controller for the single-issue CPU datapath.
// Owns the program counter, fetches from instruction RAM, latches the instruction word,
// evaluates the condition field against the held flag register, and sequences data-RAM
// access and register write-back. One instruction in flight at a time.
//
// Ports:
//   clk_i          clock, all state updates on the rising edge
//   rst_i          synchronous active-high reset
//   start_i        begin execution at pc 0 (sampled only in IDLE/HALT)
//   instr_en_o     instruction RAM enable (FETCH)
//   instr_rw_o     instruction RAM direction, always read (1)
//   instr_addr_o   instruction RAM address, zero-extended pc
//   instr_data_i   instruction RAM read data, valid the cycle after instr_en_o
//   instr_o        latched instruction register
//   new_flag_i     ALU flag result {N,Z,C,V}
//   flag_o         held flag register {N,Z,C,V}
//   mem_addr_i     data address computed by memory control
//   mem_en_o       data RAM enable (MEM)
//   mem_rw_o       data RAM direction, 1 read (LDR) / 0 write (STR)
//   mem_addr_o     data RAM address
//   reg_we_o       register bank write strobe (WB)
//   pc_o           program counter
//   busy_o         high outside IDLE/HALT
//   halted_o       high in HALT
module cpu_sequencer #(
    parameter int unsigned PC_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic                  instr_en_o,
    output logic                  instr_rw_o,
    output logic [ADDR_WIDTH-1:0] instr_addr_o,
    input  logic [31:0]           instr_data_i,
    output logic [31:0]           instr_o,
    input  logic [3:0]            new_flag_i,
    output logic [3:0]            flag_o,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    output logic                  mem_en_o,
    output logic                  mem_rw_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  reg_we_o,
    output logic [PC_WIDTH-1:0]   pc_o,
    output logic                  busy_o,
    output logic                  halted_o
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExecute,
        StMem,
        StWb,
        StHalt
    } state_e;

    localparam logic [3:0] CondHalt = 4'hF;
    localparam logic [3:0] OpLdr    = 4'hE;
    localparam logic [3:0] OpStr    = 4'hF;

    state_e                  state_q, state_d;
    logic [PC_WIDTH-1:0]     pc_q, pc_d;
    logic [31:0]             ir_q, ir_d;
    logic [3:0]              flag_q, flag_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;

    logic [3:0] cond;
    logic [3:0] opcode;
    logic       is_ldr;
    logic       is_mem_op;
    logic       cond_pass;
    logic       f_n, f_z, f_c, f_v;

    assign cond      = ir_q[31:28];
    assign opcode    = ir_q[27:24];
    assign is_ldr    = (opcode == OpLdr);
    assign is_mem_op = (opcode == OpLdr) || (opcode == OpStr);

    assign f_n = flag_q[3];
    assign f_z = flag_q[2];
    assign f_c = flag_q[1];
    assign f_v = flag_q[0];

    // Condition evaluation against the held flags; 4'hF (halt) is decoded separately.
    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'h0:    cond_pass = f_z;
            4'h1:    cond_pass = !f_z;
            4'h2:    cond_pass = f_c;
            4'h3:    cond_pass = !f_c;
            4'h4:    cond_pass = f_n;
            4'h5:    cond_pass = !f_n;
            4'h6:    cond_pass = f_v;
            4'h7:    cond_pass = !f_v;
            4'h8:    cond_pass = f_c && !f_z;
            4'h9:    cond_pass = !f_c || f_z;
            4'hA:    cond_pass = (f_n == f_v);
            4'hB:    cond_pass = (f_n != f_v);
            4'hC:    cond_pass = !f_z && (f_n == f_v);
            4'hD:    cond_pass = f_z || (f_n != f_v);
            4'hE:    cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        flag_d     = flag_q;
        mem_addr_d = mem_addr_q;
        instr_en_o = 1'b0;
        mem_en_o   = 1'b0;
        reg_we_o   = 1'b0;
        mem_rw_o   = 1'b1;
        mem_addr_o = mem_addr_q;

        case (state_q)
            StIdle, StHalt: begin
                if (start_i) begin
                    pc_d    = '0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                instr_en_o = 1'b1;
                state_d    = StDecode;
            end
            StDecode: begin
                ir_d    = instr_data_i;
                state_d = StExecute;
            end
            StExecute: begin
                if (cond == CondHalt) begin
                    // pc is left pointing at the halt word
                    state_d = StHalt;
                end else if (!cond_pass) begin
                    pc_d    = pc_q + 1'b1;
                    state_d = StFetch;
                end else if (is_mem_op) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                mem_en_o   = 1'b1;
                mem_rw_o   = is_ldr;
                mem_addr_o = mem_addr_i;
                // Keep the last driven address visible after MEM
                mem_addr_d = mem_addr_i;
                if (is_ldr) begin
                    state_d = StWb;
                end else begin
                    pc_d    = pc_q + 1'b1;
                    state_d = StFetch;
                end
            end
            StWb: begin
                reg_we_o = 1'b1;
                // Only ALU ops with S set touch the flags; loads never do
                if (!is_mem_op && ir_q[23]) begin
                    flag_d = new_flag_i;
                end
                pc_d    = pc_q + 1'b1;
                state_d = StFetch;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            pc_q       <= '0;
            ir_q       <= '0;
            flag_q     <= '0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            flag_q     <= flag_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign instr_rw_o   = 1'b1;
    assign instr_addr_o = ADDR_WIDTH'(pc_q);
    assign instr_o      = ir_q;
    assign flag_o       = flag_q;
    assign pc_o         = pc_q;
    assign busy_o       = (state_q != StIdle) && (state_q != StHalt);
    assign halted_o     = (state_q == StHalt);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: stimulus pushes expected strobe events
// (fetch / mem / write-back / halt) with their cycle offsets from start; a
// negedge monitor pops and compares whenever the DUT raises a strobe.
module tb_cpu_sequencer;

    localparam int PW = 8;
    localparam int AW = 16;

    localparam int KFetch = 0;
    localparam int KMem   = 1;
    localparam int KWb    = 2;
    localparam int KHalt  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          instr_en;
    logic          instr_rw;
    logic [AW-1:0] instr_addr;
    logic [31:0]   instr_data = '0;
    logic [31:0]   instr;
    logic [3:0]    new_flag;
    logic [3:0]    flag;
    logic [AW-1:0] mem_addr_in;
    logic          mem_en;
    logic          mem_rw;
    logic [AW-1:0] mem_addr;
    logic          reg_we;
    logic [PW-1:0] pc;
    logic          busy;
    logic          halted;

    cpu_sequencer #(
        .PC_WIDTH  (PW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .instr_en_o  (instr_en),
        .instr_rw_o  (instr_rw),
        .instr_addr_o(instr_addr),
        .instr_data_i(instr_data),
        .instr_o     (instr),
        .new_flag_i  (new_flag),
        .flag_o      (flag),
        .mem_addr_i  (mem_addr_in),
        .mem_en_o    (mem_en),
        .mem_rw_o    (mem_rw),
        .mem_addr_o  (mem_addr),
        .reg_we_o    (reg_we),
        .pc_o        (pc),
        .busy_o      (busy),
        .halted_o    (halted)
    );

    always #5 clk = ~clk;

    // Instruction RAM: registered read, data valid the cycle after instr_en
    logic [31:0] imem  [256];
    logic [3:0]  nflag [256];

    always @(posedge clk) begin
        if (instr_en) instr_data <= imem[instr_addr[7:0]];
    end

    // ALU flag result modelled as a per-pc table
    assign new_flag = nflag[pc];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          kind;
        int          rel;
        int          val;
        int          rw;
        logic [3:0]  flg;
        logic [31:0] ir;
    } exp_t;

    exp_t exp_q[$];
    int   nchk = 0;
    int   nerr = 0;
    int   base = 0;
    logic halted_prev = 1'b0;

    function automatic void push(input int kind, input int rel, input int val, input int rw,
                                 input logic [3:0] f, input logic [31:0] ir);
        exp_t e;
        e.kind = kind;
        e.rel  = rel;
        e.val  = val;
        e.rw   = rw;
        e.flg  = f;
        e.ir   = ir;
        exp_q.push_back(e);
    endfunction

    // Monitor
    always @(negedge clk) begin : mon
        exp_t e;
        int   k;
        int   v;
        int   rw;
        bit   hit;
        hit = 1'b1;
        k   = 0;
        v   = 0;
        rw  = 0;
        if (instr_en) begin
            k = KFetch; v = int'(instr_addr); rw = int'(instr_rw);
        end else if (mem_en) begin
            k = KMem;   v = int'(mem_addr);   rw = int'(mem_rw);
        end else if (reg_we) begin
            k = KWb;    v = int'(pc);         rw = int'(mem_rw);
        end else if (halted && !halted_prev) begin
            k = KHalt;  v = int'(pc);         rw = int'(mem_rw);
        end else begin
            hit = 1'b0;
        end
        halted_prev <= halted;
        if (hit) begin
            nchk++;
            if (exp_q.size() == 0) begin
                nerr++;
                $display("FAIL unexpected_event: got kind=%0d val=%0h rel=%0d, required no event",
                         k, v, cyc - base);
            end else begin
                e = exp_q.pop_front();
                if (k != e.kind || (cyc - base) != e.rel || v != e.val || rw != e.rw ||
                    flag != e.flg || (k != KFetch && instr != e.ir)) begin
                    nerr++;
                    $display({"FAIL event: got kind=%0d rel=%0d val=%0h rw=%0d flag=%b ir=%h,",
                              " required kind=%0d rel=%0d val=%0h rw=%0d flag=%b ir=%h"},
                             k, cyc - base, v, rw, flag, instr,
                             e.kind, e.rel, e.val, e.rw, e.flg, e.ir);
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int req);
        nchk++;
        if (got != req) begin
            nerr++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_halted"}, int'(halted), 0);
        chk({tag, "_pc"}, int'(pc), 0);
        chk({tag, "_flag"}, int'(flag), 0);
        chk({tag, "_instr"}, int'(instr), 0);
        chk({tag, "_strobes"}, int'({instr_en, mem_en, reg_we}), 0);
        chk({tag, "_rw"}, int'({instr_rw, mem_rw}), 3);
        chk({tag, "_mem_addr"}, int'(mem_addr), 0);
    endtask

    task automatic do_start(input string tag);
        @(negedge clk); #1;
        start = 1'b1;
        base  = cyc;
        @(negedge clk); #1;
        start = 1'b0;
        chk({tag, "_start_busy"}, int'(busy), 1);
        chk({tag, "_start_halted"}, int'(halted), 0);
    endtask

    task automatic wait_drain(input int max, input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max) begin
            @(posedge clk);
            n++;
        end
        nchk++;
        if (exp_q.size() != 0) begin
            nerr++;
            $display("FAIL %s_timeout: got %0d pending events, required 0", tag, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk); #1;
    endtask

    initial begin
        int n;
        rst         = 1'b1;
        start       = 1'b0;
        mem_addr_in = 16'h0003;
        for (int i = 0; i < 256; i++) begin
            imem[i]  = 32'h0;
            nflag[i] = 4'b1001;
        end
        repeat (2) @(negedge clk);
        check_reset("init");
        rst = 1'b0;

        // Run A: ALU(S) / LDR / STR / NE-fail / EQ-pass ALU(S) / halt at pc 5
        imem[0]  = 32'hE0800000;
        imem[1]  = 32'hEE000000;
        imem[2]  = 32'hEF000000;
        imem[3]  = 32'h10000000;
        imem[4]  = 32'h00800000;
        imem[5]  = 32'hF0000000;
        nflag[0] = 4'b0100;
        push(KFetch,  1, 0, 1, 4'b0000, 32'h0);
        push(KWb,     4, 0, 1, 4'b0000, 32'hE0800000);
        push(KFetch,  5, 1, 1, 4'b0100, 32'h0);
        push(KMem,    8, 3, 1, 4'b0100, 32'hEE000000);
        push(KWb,     9, 1, 1, 4'b0100, 32'hEE000000);
        push(KFetch, 10, 2, 1, 4'b0100, 32'h0);
        push(KMem,   13, 3, 0, 4'b0100, 32'hEF000000);
        push(KFetch, 14, 3, 1, 4'b0100, 32'h0);
        push(KFetch, 17, 4, 1, 4'b0100, 32'h0);
        push(KWb,    20, 4, 1, 4'b0100, 32'h00800000);
        push(KFetch, 21, 5, 1, 4'b1001, 32'h0);
        push(KHalt,  24, 5, 1, 4'b1001, 32'hF0000000);
        do_start("runA");
        wait_drain(100, "runA");
        chk("runA_halted", int'(halted), 1);
        chk("runA_busy", int'(busy), 0);
        chk("runA_pc", int'(pc), 5);
        chk("runA_flag", int'(flag), 4'b1001);
        chk("runA_mem_rw_idle", int'(mem_rw), 1);
        chk("runA_mem_addr_hold", int'(mem_addr), 3);

        // Run B: restart from HALT, EQ fails (Z=0) up to pc 255, ALU(S) there wraps pc to 0
        for (int i = 0; i < 256; i++) begin
            imem[i]  = 32'h0;
            nflag[i] = 4'b0000;
        end
        imem[255]  = 32'hE0800000;
        nflag[255] = 4'b0100;
        for (int k = 0; k < 256; k++) push(KFetch, 1 + 3 * k, k, 1, 4'b1001, 32'h0);
        push(KWb,    769, 255, 1, 4'b1001, 32'hE0800000);
        push(KFetch, 770, 0,   1, 4'b0100, 32'h0);
        do_start("runB");
        wait_drain(900, "runB");
        rst = 1'b1;
        @(negedge clk);
        check_reset("rstB");
        #1 rst = 1'b0;

        // Run C: fail word then STR; reset asserted during its MEM cycle
        imem[0]     = 32'h00000000;
        imem[1]     = 32'hEF000000;
        mem_addr_in = 16'h0007;
        push(KFetch, 1, 0, 1, 4'b0000, 32'h0);
        push(KFetch, 4, 1, 1, 4'b0000, 32'h0);
        push(KMem,   7, 7, 0, 4'b0000, 32'hEF000000);
        do_start("runC");
        n = 0;
        while (!mem_en && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        chk("runC_mem_seen", int'(mem_en), 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset("rstC");
        chk("runC_drain", exp_q.size(), 0);
        #1 rst = 1'b0;

        // Run D: start pulses while busy must be ignored
        imem[0] = 32'hE0000000;
        imem[1] = 32'hF0000000;
        push(KFetch, 1, 0, 1, 4'b0000, 32'h0);
        push(KWb,    4, 0, 1, 4'b0000, 32'hE0000000);
        push(KFetch, 5, 1, 1, 4'b0000, 32'h0);
        push(KHalt,  8, 1, 1, 4'b0000, 32'hF0000000);
        do_start("runD");
        @(negedge clk); #1 start = 1'b1;
        @(negedge clk); #1 start = 1'b0;
        @(negedge clk); #1 start = 1'b1;
        @(negedge clk); #1 start = 1'b0;
        wait_drain(40, "runD");
        chk("runD_halted", int'(halted), 1);
        chk("runD_busy", int'(busy), 0);
        chk("runD_pc", int'(pc), 1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
